// File: rtl/lsu_axi_master.sv
// ============================================================================
// Module   : lsu_axi_master
// Purpose  : Load/store unit bus master. Turns one core load/store request at
//            a time into single-beat AXI-lite style read or write transactions,
//            with lane shifting, load sign/zero extension, misalignment
//            detection and a per-handshake timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_axi_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  // core request / response
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [2:0]  req_size_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  // write address / data / response
  output logic        mem_awvalid_o,
  input  logic        mem_awready_i,
  output logic [31:0] mem_awaddr_o,
  output logic        mem_wvalid_o,
  input  logic        mem_wready_i,
  output logic [31:0] mem_wdata_o,
  output logic [7:0]  mem_wstrb_o,
  input  logic        mem_bvalid_i,
  output logic        mem_bready_o,
  input  logic [1:0]  mem_bresp_i,
  // read address / data
  output logic        mem_arvalid_o,
  input  logic        mem_arready_i,
  output logic [31:0] mem_araddr_o,
  input  logic        mem_rvalid_i,
  output logic        mem_rready_o,
  input  logic [1:0]  mem_rresp_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int c_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TMO = c_CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WREQ  = 3'd3,
    S_WRESP = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [2:0]           size_q, size_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;

  logic                 w_bad;
  logic                 w_tmo;
  logic [31:0]          w_rshift;
  logic [31:0]          w_load;
  logic [3:0]           w_strb4;

  // Request legality: illegal funct3 codes or misaligned half/word accesses
  always_comb begin
    w_bad = 1'b0;
    case (req_size_i)
      3'b000, 3'b100: w_bad = 1'b0;
      3'b001, 3'b101: w_bad = req_addr_i[0];
      3'b010:         w_bad = (req_addr_i[1:0] != 2'b00);
      default:        w_bad = 1'b1;
    endcase
  end

  // Load lane extraction and sign/zero extension of the returned word
  always_comb begin
    w_rshift = mem_rdata_i >> {addr_q[1:0], 3'b000};
    w_load   = w_rshift;
    case (size_q)
      3'b000:  w_load = {{24{w_rshift[7]}},  w_rshift[7:0]};
      3'b001:  w_load = {{16{w_rshift[15]}}, w_rshift[15:0]};
      3'b100:  w_load = {24'h0, w_rshift[7:0]};
      3'b101:  w_load = {16'h0, w_rshift[15:0]};
      default: w_load = w_rshift;
    endcase
  end

  // Store byte-enable pattern before lane shifting
  always_comb begin
    case (size_q[1:0])
      2'b00:   w_strb4 = 4'b0001;
      2'b01:   w_strb4 = 4'b0011;
      default: w_strb4 = 4'b1111;
    endcase
  end

  assign w_tmo = (cnt_q == c_TMO);

  // Next-state and datapath capture for the transaction sequencer
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d    = req_addr_i;
          size_d    = req_size_i;
          wdata_d   = req_wdata_i;
          rdata_d   = 32'h0;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (w_bad) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (req_wen_i) begin
            state_d = S_WREQ;
          end else begin
            state_d = S_RADDR;
          end
        end
      end
      S_RADDR: begin
        // arvalid is held high for the whole state, so arready is the handshake
        if (mem_arready_i) begin
          state_d = S_RDATA;
        end else if (w_tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RDATA: begin
        if (mem_rvalid_i) begin
          err_d   = (mem_rresp_i != 2'b00);
          rdata_d = (mem_rresp_i != 2'b00) ? 32'h0 : w_load;
          state_d = S_DONE;
        end else if (w_tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WREQ: begin
        aw_done_d = aw_done_q | mem_awready_i;
        w_done_d  = w_done_q  | mem_wready_i;
        if ((aw_done_q | mem_awready_i) && (w_done_q | mem_wready_i)) begin
          state_d = S_WRESP;
        end else if (w_tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WRESP: begin
        if (mem_bvalid_i) begin
          err_d   = (mem_bresp_i != 2'b00);
          state_d = S_DONE;
        end else if (w_tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake timer restarts on every state change and idles at zero
  always_comb begin
    if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_DONE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State and capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= 32'h0;
      size_q    <= 3'b000;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
    end
  end

  // Bus outputs come from registered state only, never from slave readies
  assign req_ready_o   = (state_q == S_IDLE) && !rst;
  assign rsp_valid_o   = (state_q == S_DONE);
  assign rsp_err_o     = (state_q == S_DONE) && err_q;
  assign rsp_rdata_o   = (state_q == S_DONE) ? rdata_q : 32'h0;

  assign mem_arvalid_o = (state_q == S_RADDR);
  assign mem_rready_o  = (state_q == S_RADDR) || (state_q == S_RDATA);
  assign mem_araddr_o  = {addr_q[31:2], 2'b00};

  assign mem_awvalid_o = (state_q == S_WREQ) && !aw_done_q;
  assign mem_wvalid_o  = (state_q == S_WREQ) && !w_done_q;
  assign mem_bready_o  = (state_q == S_WREQ) || (state_q == S_WRESP);
  assign mem_awaddr_o  = {addr_q[31:2], 2'b00};
  assign mem_wdata_o   = wdata_q << {addr_q[1:0], 3'b000};
  assign mem_wstrb_o   = {4'b0000, w_strb4 << addr_q[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_lsu_axi_master.sv
// ============================================================================
// Module   : tb_lsu_axi_master
// Purpose  : Self-checking bench for lsu_axi_master with a reactive slave,
//            a response scoreboard, a vector table and corner-case sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_axi_master;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] araddr, rdata;
  logic [1:0]  rresp;

  always #5 clk = ~clk;

  lsu_axi_master #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wen_i(req_wen),
    .req_size_i(req_size), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_awvalid_o(awvalid), .mem_awready_i(awready), .mem_awaddr_o(awaddr),
    .mem_wvalid_o(wvalid), .mem_wready_i(wready), .mem_wdata_o(wdata),
    .mem_wstrb_o(wstrb), .mem_bvalid_i(bvalid), .mem_bready_o(bready),
    .mem_bresp_i(bresp), .mem_arvalid_o(arvalid), .mem_arready_i(arready),
    .mem_araddr_o(araddr), .mem_rvalid_i(rvalid), .mem_rready_o(rready),
    .mem_rresp_i(rresp), .mem_rdata_i(rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        wen;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] srdata;
    logic [1:0]  sresp;
    int          dly;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_bus;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [7:0]  exp_wstrb;
  } vec_t;
  vec_t vecs[15];

  int tests = 0;
  int fails = 0;
  int rsp_cnt = 0;
  int bus_cyc = 0;

  // slave configuration and expected bus-side values
  int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
  logic        mute;
  logic [31:0] s_rdata;
  logic [1:0]  s_resp;
  logic [31:0] g_addr, g_wdata;
  logic [7:0]  g_wstrb;

  // slave internal state
  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic        r_pend, b_aw, b_w;
  logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
  logic [31:0] p_ara, p_awa, p_wd;
  logic [7:0]  p_ws;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reactive slave + protocol monitor + response scoreboard, all on negedge
  initial begin
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    r_pend = 0; b_aw = 0; b_w = 0;
    p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
    p_ara = 0; p_awa = 0; p_wd = 0; p_ws = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        r_pend = 0; b_aw = 0; b_w = 0;
      end else begin
        if (arvalid || awvalid || wvalid) bus_cyc++;
        // a valid that was not accepted must still be there, unchanged
        if (!mute) begin
          if (p_arv && !p_arr) chk("ar_hold", {arvalid, araddr == p_ara}, 2'b11);
          if (p_awv && !p_awr) chk("aw_hold", {awvalid, awaddr == p_awa}, 2'b11);
          if (p_wv && !p_wr)   chk("w_hold", {wvalid, (wdata == p_wd) && (wstrb == p_ws)}, 2'b11);
        end
        // AR channel
        if (arready) begin
          arready = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0;
          chk("ar_drop", arvalid, 0);
        end else if (arvalid && !mute) begin
          if (ar_cnt >= ar_dly) begin
            arready = 1;
            chk("araddr", araddr, g_addr);
            chk("ar_rready", rready, 1);
          end else ar_cnt++;
        end
        // R channel
        if (rvalid) begin
          rvalid = 0; rdata = 0; rresp = 0;
        end else if (r_pend) begin
          if (r_cnt >= r_dly) begin
            rvalid = 1; rdata = s_rdata; rresp = s_resp; r_pend = 0;
          end else r_cnt++;
        end
        // AW channel
        if (awready) begin
          awready = 0; aw_cnt = 0; b_aw = 1;
          chk("aw_drop", awvalid, 0);
        end else if (awvalid && !mute) begin
          if (aw_cnt >= aw_dly) begin
            awready = 1;
            chk("awaddr", awaddr, g_addr);
            chk("aw_bready", bready, 1);
          end else aw_cnt++;
        end
        // W channel
        if (wready) begin
          wready = 0; w_cnt = 0; b_w = 1;
          chk("w_drop", wvalid, 0);
        end else if (wvalid && !mute) begin
          if (w_cnt >= w_dly) begin
            wready = 1;
            chk("wdata", wdata, g_wdata);
            chk("wstrb", {24'h0, wstrb}, {24'h0, g_wstrb});
          end else w_cnt++;
        end
        // B channel
        if (bvalid) begin
          bvalid = 0; bresp = 0;
        end else if (b_aw && b_w) begin
          if (b_cnt >= b_dly) begin
            bvalid = 1; bresp = s_resp; b_aw = 0; b_w = 0; b_cnt = 0;
          end else b_cnt++;
        end
      end
      if (rsp_valid) begin
        rsp_cnt++;
        if (sb.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
        end
      end
      p_arv = arvalid; p_arr = arready; p_ara = araddr;
      p_awv = awvalid; p_awr = awready; p_awa = awaddr;
      p_wv = wvalid; p_wr = wready; p_wd = wdata; p_ws = wstrb;
    end
  end

  task automatic do_req(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rdata,
                        input logic exp_err, input logic exp_bus, output int lat);
    int   n0, b0, w;
    exp_t e;
    @(negedge clk); #1;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); #1; w++; end
    chk("req_ready_idle", req_ready, 1);
    n0 = rsp_cnt; b0 = bus_cyc;
    e.rdata = exp_rdata; e.err = exp_err;
    sb.push_back(e);
    req_valid = 1; req_wen = wen; req_size = size; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 0;
    while (rsp_cnt == n0 && lat < TMO + 20) begin @(negedge clk); #1; lat++; end
    chk("rsp_arrived", rsp_cnt - n0, 1);
    if (rsp_cnt == n0) sb.delete();
    if (!exp_bus) chk("no_bus_activity", bus_cyc - b0, 0);
    @(negedge clk); #1;
    chk("rsp_one_cycle", rsp_valid, 0);
    chk("ready_after_done", req_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n0, w;
    vecs[0]  = '{1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 2'd0, 3, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h8000_0004, 32'h0, 8'h00};
    vecs[1]  = '{1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 2'd0, 1, 32'hFFFF_FF80, 1'b0, 1'b1, 32'h8000_0000, 32'h0, 8'h00};
    vecs[2]  = '{1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 2'd0, 0, 32'h0000_0080, 1'b0, 1'b1, 32'h8000_0000, 32'h0, 8'h00};
    vecs[3]  = '{1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h8001_1234, 2'd0, 2, 32'hFFFF_8001, 1'b0, 1'b1, 32'h8000_0000, 32'h0, 8'h00};
    vecs[4]  = '{1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h8001_1234, 2'd0, 0, 32'h0000_8001, 1'b0, 1'b1, 32'h8000_0000, 32'h0, 8'h00};
    vecs[5]  = '{1'b0, 3'b000, 32'h8000_0001, 32'h0, 32'h0000_7F00, 2'd0, 1, 32'h0000_007F, 1'b0, 1'b1, 32'h8000_0000, 32'h0, 8'h00};
    vecs[6]  = '{1'b0, 3'b010, 32'h8000_0008, 32'h0, 32'h1234_5678, 2'd2, 1, 32'h0000_0000, 1'b1, 1'b1, 32'h8000_0008, 32'h0, 8'h00};
    vecs[7]  = '{1'b1, 3'b001, 32'h8000_0002, 32'h0000_1234, 32'h0, 2'd0, 2, 32'h0, 1'b0, 1'b1, 32'h8000_0000, 32'h1234_0000, 8'h0C};
    vecs[8]  = '{1'b1, 3'b000, 32'h8000_0001, 32'h1234_56AB, 32'h0, 2'd0, 0, 32'h0, 1'b0, 1'b1, 32'h8000_0000, 32'h3456_AB00, 8'h02};
    vecs[9]  = '{1'b1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 32'h0, 2'd0, 1, 32'h0, 1'b0, 1'b1, 32'h8000_0008, 32'hCAFE_F00D, 8'h0F};
    vecs[10] = '{1'b1, 3'b010, 32'h8000_000C, 32'h0000_0001, 32'h0, 2'd3, 1, 32'h0, 1'b1, 1'b1, 32'h8000_000C, 32'h0000_0001, 8'h0F};
    vecs[11] = '{1'b0, 3'b010, 32'h8000_0001, 32'h0, 32'h0, 2'd0, 0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 8'h00};
    vecs[12] = '{1'b0, 3'b001, 32'h8000_0003, 32'h0, 32'h0, 2'd0, 0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 8'h00};
    vecs[13] = '{1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 2'd0, 0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 8'h00};
    vecs[14] = '{1'b1, 3'b001, 32'h8000_0001, 32'h0000_5555, 32'h0, 2'd0, 0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 8'h00};

    rst = 1; req_valid = 0; req_wen = 0; req_size = 0; req_addr = 0; req_wdata = 0;
    mute = 0; ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
    s_rdata = 0; s_resp = 0; g_addr = 0; g_wdata = 0; g_wstrb = 0;
    #1;
    chk("reset_outputs", {req_ready, rsp_valid, rsp_err, arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("reset_rdata", rsp_rdata, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("ready_after_reset", req_ready, 1);

    // table of single transactions
    for (int i = 0; i < 15; i++) begin
      ar_dly = vecs[i].dly; r_dly = vecs[i].dly; aw_dly = vecs[i].dly;
      b_dly = vecs[i].dly; w_dly = 0;
      s_rdata = vecs[i].srdata; s_resp = vecs[i].sresp;
      g_addr = vecs[i].exp_addr; g_wdata = vecs[i].exp_wdata; g_wstrb = vecs[i].exp_wstrb;
      do_req(vecs[i].wen, vecs[i].size, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_bus, lat);
      if (!vecs[i].exp_bus) chk("misaligned_latency", lat <= 2, 1);
    end

    // awready arrives several cycles after wready: w drops, aw holds
    aw_dly = 5; w_dly = 0; b_dly = 0; s_resp = 0;
    g_addr = 32'h8000_0010; g_wdata = 32'hA5A5_0001; g_wstrb = 8'h0F;
    do_req(1'b1, 3'b010, 32'h8000_0010, 32'hA5A5_0001, 32'h0, 1'b0, 1'b1, lat);

    // wready arrives after awready
    aw_dly = 0; w_dly = 3;
    g_addr = 32'h8000_0014; g_wdata = 32'h0000_00EE; g_wstrb = 8'h01;
    do_req(1'b1, 3'b000, 32'h8000_0014, 32'h0000_00EE, 32'h0, 1'b0, 1'b1, lat);
    w_dly = 0;

    // silent slave: load and store both time out with an error
    mute = 1;
    do_req(1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'h0, 1'b1, 1'b1, lat);
    chk("tmo_load_latency", (lat >= TMO) && (lat <= TMO + 4), 1);
    do_req(1'b1, 3'b010, 32'h8000_0024, 32'h1, 32'h0, 1'b1, 1'b1, lat);
    chk("tmo_store_latency", (lat >= TMO) && (lat <= TMO + 4), 1);
    mute = 0;

    // reset while waiting for read data aborts silently
    ar_dly = 0; r_dly = 10; s_rdata = 32'h1111_2222; s_resp = 0; g_addr = 32'h8000_0040;
    @(negedge clk); #1;
    n0 = rsp_cnt;
    req_valid = 1; req_wen = 0; req_size = 3'b010; req_addr = 32'h8000_0040; req_wdata = 0;
    @(posedge clk); #1;
    req_valid = 0;
    w = 0;
    while (!r_pend && w < 20) begin @(negedge clk); #1; w++; end
    chk("reached_rdata", r_pend, 1);
    @(negedge clk); #2;
    rst = 1;
    #1;
    chk("abort_outputs", {req_ready, rsp_valid, rsp_err, arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("abort_rdata", rsp_rdata, 0);
    @(negedge clk);
    @(negedge clk); #1;
    rst = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_no_rsp", rsp_cnt - n0, 0);
    ar_dly = 1; r_dly = 1; s_rdata = 32'h0BAD_F00D; g_addr = 32'h8000_0040;
    do_req(1'b0, 3'b010, 32'h8000_0040, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b1, lat);

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
